// File: rtl/tt_sweep_capture_pkg.sv
// Shared types and sizes for the truth-table sweep/capture block.
package tt_pkg;

  localparam int unsigned NUM_INPUTS = 7;
  localparam int unsigned TT_BITS    = 2 ** NUM_INPUTS;
  localparam int unsigned ONES_W     = NUM_INPUTS + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef logic [TT_BITS-1:0] tt_t;

endpackage

// File: rtl/tt_sweep_capture_if.sv
// Result hand-off bus: captured table, match flag, popcount, valid/ready.
interface tt_sweep_capture_if;
  import tt_pkg::*;

  tt_t               tt_data;
  logic              tt_valid;
  logic              tt_ready;
  logic              match;
  logic [ONES_W-1:0] ones_count;

  modport master (
    output tt_data,
    output tt_valid,
    input  tt_ready,
    output match,
    output ones_count
  );

  modport slave (
    input  tt_data,
    input  tt_valid,
    output tt_ready,
    input  match,
    input  ones_count
  );

endinterface

// File: rtl/tt_sweep_capture.sv
// Sweeps a 7-input combinational function through all minterms, captures the
// 128-bit truth table, compares it against a latched signature and offers it
// on a valid/ready bus.
// Optional: define TT_SWEEP_POPCOUNT_EN to count ones in the captured table;
// otherwise ones_count is tied to zero.
module tt_sweep_capture
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic [NUM_INPUTS-1:0] x_out,
  input  logic                  f_in,
  input  tt_t                   expected_tt,
  tt_sweep_capture_if.master    tt_if
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]      SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [NUM_INPUTS-1:0] IDX_LAST    = NUM_INPUTS'(TT_BITS - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("tt_sweep_capture: SETTLE_CYCLES must be >= 1");
  end

  state_e                state_q;
  state_e                state_d;
  logic [NUM_INPUTS-1:0] idx_q;
  logic [CNT_W-1:0]      cnt_q;
  tt_t                   exp_q;
  tt_t                   tt_q;
  tt_t                   tt_next;
  logic                  valid_q;
  logic                  match_q;
  logic                  last_c;

  assign last_c = (idx_q == IDX_LAST);

  // Table as it will look once the current minterm's output is written.
  always_comb begin
    tt_next        = tt_q;
    tt_next[idx_q] = f_in;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: settle, sample, and terminal handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (cnt_q == CNT_W'(1)) state_d = SAMPLE;
      SAMPLE:  state_d = last_c ? DONE : DRIVE;
      DONE:    if (tt_if.tt_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: index/settle counters, capture register, match and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      x_out   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      tt_q    <= '0;
      valid_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (start) begin
            exp_q   <= expected_tt;
            tt_q    <= '0;
            match_q <= 1'b0;
            idx_q   <= '0;
            x_out   <= '0;
            cnt_q   <= SETTLE_LOAD;
          end
        end
        DRIVE: begin
          if (cnt_q != CNT_W'(1)) cnt_q <= cnt_q - CNT_W'(1);
        end
        SAMPLE: begin
          tt_q <= tt_next;
          if (last_c) begin
            match_q <= (tt_next == exp_q);
            valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + NUM_INPUTS'(1);
            x_out <= idx_q + NUM_INPUTS'(1);
            cnt_q <= SETTLE_LOAD;
          end
        end
        DONE: begin
          if (tt_if.tt_ready) valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign tt_if.tt_data  = tt_q;
  assign tt_if.tt_valid = valid_q;
  assign tt_if.match    = match_q;

`ifdef TT_SWEEP_POPCOUNT_EN
  logic [ONES_W-1:0] ones_q;

  // Running count of ones captured during the current sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q <= '0;
    end else if (state_q == IDLE && start) begin
      ones_q <= '0;
    end else if (state_q == SAMPLE && f_in) begin
      ones_q <= ones_q + ONES_W'(1);
    end
  end

  assign tt_if.ones_count = ones_q;
`else
  assign tt_if.ones_count = '0;
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Self-checking bench for tt_sweep_capture: two instances (settle 1 and 3)
// driven from behavioural function models and checked against a table model.
module tb_tt_sweep_capture;
  import tt_pkg::*;

  localparam tt_t SIG  = 128'hfefefea8fec8e880fee8ec80ea808080;
  localparam tt_t ALT  = {64{2'b10}};
  localparam tt_t HIGH = {{64{1'b1}}, {64{1'b0}}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rst;
  logic [1:0]                   start_a;
  logic [1:0][TT_BITS-1:0]      exp_a;
  logic [1:0]                   ready_a;
  int                           fsel_a [2];
  logic [1:0]                   busy_w;
  logic [1:0][NUM_INPUTS-1:0]   x_w;
  logic [1:0]                   f_w;
  logic [1:0][TT_BITS-1:0]      data_w;
  logic [1:0]                   valid_w;
  logic [1:0]                   match_w;
  logic [1:0][ONES_W-1:0]       ones_w;
  tt_t                          sig_tab;
  tt_t                          rand_tab;
  int                           errors = 0;
  int                           checks = 0;

  tt_sweep_capture_if if0 ();
  tt_sweep_capture_if if1 ();

  assign if0.tt_ready = ready_a[0];
  assign if1.tt_ready = ready_a[1];
  assign data_w[0]    = if0.tt_data;
  assign data_w[1]    = if1.tt_data;
  assign valid_w[0]   = if0.tt_valid;
  assign valid_w[1]   = if1.tt_valid;
  assign match_w[0]   = if0.match;
  assign match_w[1]   = if1.match;
  assign ones_w[0]    = if0.ones_count;
  assign ones_w[1]    = if1.ones_count;

  tt_sweep_capture #(.SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_a[0]), .busy(busy_w[0]), .x_out(x_w[0]),
    .f_in(f_w[0]), .expected_tt(exp_a[0]), .tt_if(if0.master)
  );

  tt_sweep_capture #(.SETTLE_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .busy(busy_w[1]), .x_out(x_w[1]),
    .f_in(f_w[1]), .expected_tt(exp_a[1]), .tt_if(if1.master)
  );

  // Function under test: 0=x0, 1=x6, 2=signature function, 3=const 0, 4=random table.
  always_comb begin
    f_w = '0;
    for (int k = 0; k < 2; k++) begin
      case (fsel_a[k])
        0:       f_w[k] = x_w[k][0];
        1:       f_w[k] = x_w[k][6];
        2:       f_w[k] = sig_tab[x_w[k]];
        4:       f_w[k] = rand_tab[x_w[k]];
        default: f_w[k] = 1'b0;
      endcase
    end
  end

  // Reference truth table obtained by evaluating the function at every minterm.
  function automatic tt_t model_tt(input int sel);
    tt_t t;
    logic [NUM_INPUTS-1:0] xi;
    t = '0;
    for (int i = 0; i < TT_BITS; i++) begin
      xi = NUM_INPUTS'(i);
      case (sel)
        0:       t[i] = xi[0];
        1:       t[i] = xi[6];
        2:       t[i] = sig_tab[i];
        4:       t[i] = rand_tab[i];
        default: t[i] = 1'b0;
      endcase
    end
    return t;
  endfunction

  function automatic logic [ONES_W-1:0] model_ones(input tt_t t);
`ifdef TT_SWEEP_POPCOUNT_EN
    return ONES_W'($countones(t));
`else
    return ONES_W'(0 * $countones(t));
`endif
  endfunction

  // Start a sweep on instance w from an IDLE negedge and follow it to tt_valid.
  task automatic run_sweep(input int w, input int sel, input tt_t exp, input int pulse_at,
                           input string tag);
    tt_t want;
    int  per, lat, n, xerr, berr, xe;
    want = model_tt(sel);
    per  = (w == 1) ? 4 : 2;
    lat  = TT_BITS * per;
    fsel_a[w]  = sel;
    exp_a[w]   = exp;
    start_a[w] = 1'b1;
    @(negedge clk);
    start_a[w] = 1'b0;
    exp_a[w]   = ~exp;
    n = 0; xerr = 0; berr = 0;
    while (valid_w[w] !== 1'b1 && n < lat + 20) begin
      xe = n / per;
      if (xe > TT_BITS - 1) xe = TT_BITS - 1;
      if (x_w[w] !== NUM_INPUTS'(xe)) xerr++;
      if (busy_w[w] !== 1'b1) berr++;
      start_a[w] = (n == pulse_at);
      @(negedge clk);
      n++;
    end
    start_a[w] = 1'b0;
    checks++;
    if (n !== lat) begin
      errors++; $display("FAIL %s latency: got %0d cycles, want %0d", tag, n, lat);
    end
    checks++;
    if (xerr !== 0) begin
      errors++; $display("FAIL %s x_out progression: %0d wrong cycles, want 0", tag, xerr);
    end
    checks++;
    if (berr !== 0) begin
      errors++; $display("FAIL %s busy during sweep: %0d low cycles, want 0", tag, berr);
    end
    checks++;
    if (data_w[w] !== want) begin
      errors++; $display("FAIL %s tt_data: got %h want %h", tag, data_w[w], want);
    end
    checks++;
    if (match_w[w] !== (want == exp)) begin
      errors++; $display("FAIL %s match: got %b want %b", tag, match_w[w], want == exp);
    end
    checks++;
    if (x_w[w] !== NUM_INPUTS'(TT_BITS - 1) || busy_w[w] !== 1'b1) begin
      errors++; $display("FAIL %s done x_out/busy: got %0d/%b want 127/1", tag, x_w[w], busy_w[w]);
    end
    checks++;
    if (ones_w[w] !== model_ones(want)) begin
      errors++; $display("FAIL %s ones_count: got %0d want %0d", tag, ones_w[w], model_ones(want));
    end
  endtask

  // With tt_ready high in DONE, the next edge completes the hand-off.
  task automatic expect_handoff(input int w, input string tag);
    @(negedge clk);
    checks++;
    if (valid_w[w] !== 1'b0 || busy_w[w] !== 1'b0) begin
      errors++;
      $display("FAIL %s handoff: valid=%b busy=%b want 0/0", tag, valid_w[w], busy_w[w]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = '0; ready_a = 2'b11; exp_a = '0;
    fsel_a[0] = 3; fsel_a[1] = 3;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_w !== 2'b00 || valid_w !== 2'b00 || match_w !== 2'b00) begin
      errors++; $display("FAIL reset flags: busy=%b valid=%b match=%b want 0", busy_w, valid_w, match_w);
    end
    checks++;
    if (x_w[0] !== '0 || x_w[1] !== '0 || data_w[0] !== '0 || data_w[1] !== '0) begin
      errors++; $display("FAIL reset data: x=%h data0=%h want 0", x_w, data_w[0]);
    end
    checks++;
    if (ones_w[0] !== '0) begin
      errors++; $display("FAIL reset ones_count: got %0d want 0", ones_w[0]);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_patterns();
    run_sweep(0, 0, ALT, -1, "alt_x0");
    expect_handoff(0, "alt_x0");
    run_sweep(0, 1, '0, -1, "msb_x6");
    checks++;
    if (data_w[0] !== HIGH) begin
      errors++; $display("FAIL msb_x6 constant table: got %h want %h", data_w[0], HIGH);
    end
    expect_handoff(0, "msb_x6");
  endtask

  task automatic test_signature_slow();
    sig_tab = SIG;
    run_sweep(1, 2, SIG, -1, "sig_settle3");
    checks++;
    if (match_w[1] !== 1'b1 || data_w[1] !== SIG) begin
      errors++; $display("FAIL sig_settle3 signature: got %h match %b want %h match 1", data_w[1], match_w[1], SIG);
    end
    expect_handoff(1, "sig_settle3");
  endtask

  task automatic test_backpressure();
    tt_t d0; logic m0; int serr;
    rand_tab = {$urandom, $urandom, $urandom, $urandom};
    ready_a[0] = 1'b0;
    run_sweep(0, 4, rand_tab, -1, "bp");
    d0 = data_w[0]; m0 = match_w[0]; serr = 0;
    for (int c = 0; c < 10; c++) begin
      start_a[0] = (c == 3);
      @(negedge clk);
      if (valid_w[0] !== 1'b1 || busy_w[0] !== 1'b1 || data_w[0] !== d0 ||
          match_w[0] !== m0 || x_w[0] !== NUM_INPUTS'(TT_BITS - 1)) serr++;
    end
    start_a[0] = 1'b0;
    checks++;
    if (serr !== 0) begin
      errors++; $display("FAIL bp stall stability: %0d unstable cycles, want 0", serr);
    end
    ready_a[0] = 1'b1;
    expect_handoff(0, "bp");
    serr = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy_w[0] !== 1'b0 || valid_w[0] !== 1'b0) serr++;
    end
    checks++;
    if (serr !== 0) begin
      errors++; $display("FAIL bp no second sweep: %0d busy cycles, want 0", serr);
    end
  endtask

  task automatic test_back_to_back();
    rand_tab = {$urandom, $urandom, $urandom, $urandom};
    ready_a[0] = 1'b0;
    run_sweep(0, 4, ~rand_tab, -1, "b2b_first");
    ready_a[0] = 1'b1;
    start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    checks++;
    if (busy_w[0] !== 1'b0 || valid_w[0] !== 1'b0) begin
      errors++; $display("FAIL b2b start at handoff: busy=%b valid=%b want 0/0", busy_w[0], valid_w[0]);
    end
    run_sweep(0, 0, ALT, -1, "b2b_second");
    expect_handoff(0, "b2b_second");
  endtask

  task automatic test_reset_mid_sweep();
    int verr;
    fsel_a[0] = 0; exp_a[0] = ALT; start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy_w[0] !== 1'b0 || valid_w[0] !== 1'b0 || match_w[0] !== 1'b0 ||
        x_w[0] !== '0 || data_w[0] !== '0 || ones_w[0] !== '0) begin
      errors++;
      $display("FAIL midrst outputs: busy=%b valid=%b match=%b x=%0d data=%h ones=%0d want all 0",
               busy_w[0], valid_w[0], match_w[0], x_w[0], data_w[0], ones_w[0]);
    end
    verr = 0;
    repeat (300) begin
      @(negedge clk);
      if (valid_w[0] !== 1'b0 || busy_w[0] !== 1'b0) verr++;
    end
    checks++;
    if (verr !== 0) begin
      errors++; $display("FAIL midrst discarded table: %0d active cycles, want 0", verr);
    end
    run_sweep(0, 3, '0, -1, "midrst_zero");
    expect_handoff(0, "midrst_zero");
  endtask

  task automatic test_start_mid_sweep();
    rand_tab = {$urandom, $urandom, $urandom, $urandom};
    run_sweep(0, 4, rand_tab, 50, "start_ignored");
    expect_handoff(0, "start_ignored");
  endtask

  task automatic test_random();
    tt_t e;
    for (int r = 0; r < 3; r++) begin
      rand_tab = {$urandom, $urandom, $urandom, $urandom};
      e = ($urandom_range(0, 1) == 1) ? rand_tab : (rand_tab ^ (tt_t'(1) << $urandom_range(0, 127)));
      run_sweep(0, 4, e, -1, "random");
      expect_handoff(0, "random");
    end
  endtask

  initial begin
    sig_tab  = SIG;
    rand_tab = '0;
    test_reset();
    test_patterns();
    test_signature_slow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_sweep();
    test_start_mid_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
